// File: rtl/nx_indirect_access_pkg.sv
// nx_indirect_access_pkg: shared op encoding, port-owner enum and parity helper for indirect access
package nx_indirect_access_pkg;
  localparam int MAX_PAR_BITS = 1024;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_COMPARE, OP_CLEAR} ia_op_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_HW, OWN_SW} owner_e;
  function automatic logic even_parity(input logic [MAX_PAR_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/nx_ia_resp_arb.sv
// nx_ia_resp_arb: combinational grant / hw_stall / owner arbitration between hardware and software ports
module nx_ia_resp_arb
  import nx_indirect_access_pkg::*;
(
  input  logic   sw_cs,
  input  logic   yield,
  input  logic   hw_rd,
  input  logic   hw_wr,
  output logic   grant,
  output logic   hw_stall,
  output owner_e owner
);
  logic hw_req;
  assign hw_req   = hw_rd | hw_wr;
  assign grant    = sw_cs & (!hw_req | yield);
  assign hw_stall = hw_req & grant;
  assign owner    = grant ? OWN_SW : hw_req ? OWN_HW : OWN_NONE;
endmodule

// File: rtl/nx_indirect_access_resp.sv
// nx_indirect_access_resp: shared register-array table with hw/sw ports and CAM compare; parity via NX_IA_RESP_PARITY_EN
module nx_indirect_access_resp
  import nx_indirect_access_pkg::*;
#(
  parameter int N_DATA_BITS   = 64,
  parameter int N_ENTRIES     = 16,
  parameter int N_ADDR_BITS   = 5,
  parameter int N_AINDEX_BITS = 4,
  parameter logic [N_DATA_BITS-1:0] RESET_DATA = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sw_cs,
  input  logic                     sw_ce,
  input  logic                     sw_we,
  input  logic [N_ADDR_BITS-1:0]   sw_add,
  input  logic [N_DATA_BITS-1:0]   sw_wdat,
  input  logic                     reset,
  input  logic                     yield,
  output logic                     grant,
  output logic [N_DATA_BITS-1:0]   sw_rdat,
  output logic                     sw_match,
  output logic [N_AINDEX_BITS-1:0] sw_aindex,
  input  logic                     hw_rd,
  input  logic                     hw_wr,
  input  logic [N_ADDR_BITS-1:0]   hw_add,
  input  logic [N_DATA_BITS-1:0]   hw_wdat,
  output logic [N_DATA_BITS-1:0]   hw_rdat,
  output logic                     hw_rvalid,
  output logic                     hw_stall
`ifdef NX_IA_RESP_PARITY_EN
  ,
  output logic                     hw_perr,
  output logic                     sw_perr
`endif
);
  localparam logic [N_ADDR_BITS:0] DEPTH = N_ENTRIES[N_ADDR_BITS:0];
  owner_e owner;
  logic [N_DATA_BITS-1:0] entries_q [N_ENTRIES];
  logic [N_DATA_BITS-1:0] sw_rdat_q, hw_rdat_q;
  logic sw_match_q, sw_match_d, hw_rvalid_q;
  logic [N_AINDEX_BITS-1:0] sw_aindex_q, sw_aindex_d;
  logic sw_ok, hw_ok, sw_wr, sw_rd, sw_cmp, hw_wr_go, hw_rd_go;
  logic [N_AINDEX_BITS-1:0] sw_idx, hw_idx;
  nx_ia_resp_arb u_arb (
    .sw_cs    (sw_cs),
    .yield    (yield),
    .hw_rd    (hw_rd),
    .hw_wr    (hw_wr),
    .grant    (grant),
    .hw_stall (hw_stall),
    .owner    (owner)
  );
  assign sw_idx   = sw_add[N_AINDEX_BITS-1:0];
  assign hw_idx   = hw_add[N_AINDEX_BITS-1:0];
  assign sw_ok    = {1'b0, sw_add} < DEPTH;
  assign hw_ok    = {1'b0, hw_add} < DEPTH;
  assign sw_wr    = grant & sw_we;
  assign sw_rd    = grant & !sw_we & !sw_ce;
  assign sw_cmp   = grant & sw_ce & !sw_we;
  assign hw_wr_go = (owner == OWN_HW) & hw_wr;
  assign hw_rd_go = (owner == OWN_HW) & hw_rd & !hw_wr;
  // scan downward so the lowest matching index wins
  always_comb begin
    sw_match_d  = 1'b0;
    sw_aindex_d = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--)
      if (entries_q[i] == sw_wdat) begin
        sw_match_d  = 1'b1;
        sw_aindex_d = N_AINDEX_BITS'(i);
      end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) entries_q[i] <= RESET_DATA;
      sw_rdat_q   <= '0;
      sw_match_q  <= 1'b0;
      sw_aindex_q <= '0;
      hw_rdat_q   <= '0;
      hw_rvalid_q <= 1'b0;
    end else begin
      if (sw_wr && sw_ok) entries_q[sw_idx] <= reset ? RESET_DATA : sw_wdat;
      if (hw_wr_go && hw_ok) entries_q[hw_idx] <= hw_wdat;
      if (sw_rd) sw_rdat_q <= sw_ok ? entries_q[sw_idx] : '0;
      if (sw_cmp) begin
        sw_match_q  <= sw_match_d;
        sw_aindex_q <= sw_aindex_d;
      end
      if (hw_rd_go) hw_rdat_q <= hw_ok ? entries_q[hw_idx] : '0;
      hw_rvalid_q <= hw_rd_go;
    end
  assign sw_rdat   = sw_rdat_q;
  assign sw_match  = sw_match_q;
  assign sw_aindex = sw_aindex_q;
  assign hw_rdat   = hw_rdat_q;
  assign hw_rvalid = hw_rvalid_q;
`ifdef NX_IA_RESP_PARITY_EN
  logic par_q [N_ENTRIES];
  logic hw_perr_q, sw_perr_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) par_q[i] <= even_parity(MAX_PAR_BITS'(RESET_DATA));
      hw_perr_q <= 1'b0;
      sw_perr_q <= 1'b0;
    end else begin
      if (sw_wr && sw_ok) par_q[sw_idx] <= even_parity(MAX_PAR_BITS'(reset ? RESET_DATA : sw_wdat));
      if (hw_wr_go && hw_ok) par_q[hw_idx] <= even_parity(MAX_PAR_BITS'(hw_wdat));
      sw_perr_q <= sw_rd && sw_ok && (par_q[sw_idx] != even_parity(MAX_PAR_BITS'(entries_q[sw_idx])));
      hw_perr_q <= hw_rd_go && hw_ok && (par_q[hw_idx] != even_parity(MAX_PAR_BITS'(entries_q[hw_idx])));
    end
  assign hw_perr = hw_perr_q;
  assign sw_perr = sw_perr_q;
`endif
endmodule

// File: tb/tb_nx_indirect_access_resp.sv
// tb_nx_indirect_access_resp: directed self-checking bench for nx_indirect_access_resp
module tb_nx_indirect_access_resp;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sw_cs = 0, sw_ce = 0, sw_we = 0, reset = 0, yield = 0;
  logic hw_rd = 0, hw_wr = 0;
  logic [4:0] sw_add = '0, hw_add = '0;
  logic [63:0] sw_wdat = '0, hw_wdat = '0;
  logic grant, sw_match, hw_rvalid, hw_stall;
  logic [63:0] sw_rdat, hw_rdat;
  logic [3:0] sw_aindex;
  int n_cmp = 0, n_bad = 0;
`ifdef NX_IA_RESP_PARITY_EN
  logic hw_perr, sw_perr;
`endif
  nx_indirect_access_resp dut (
    .clk(clk), .rst_n(rst_n), .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we),
    .sw_add(sw_add), .sw_wdat(sw_wdat), .reset(reset), .yield(yield),
    .grant(grant), .sw_rdat(sw_rdat), .sw_match(sw_match), .sw_aindex(sw_aindex),
    .hw_rd(hw_rd), .hw_wr(hw_wr), .hw_add(hw_add), .hw_wdat(hw_wdat),
    .hw_rdat(hw_rdat), .hw_rvalid(hw_rvalid), .hw_stall(hw_stall)
`ifdef NX_IA_RESP_PARITY_EN
    , .hw_perr(hw_perr), .sw_perr(sw_perr)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    sw_cs = 0; sw_ce = 0; sw_we = 0; reset = 0; yield = 0; hw_rd = 0; hw_wr = 0;
  endtask
  task automatic hww(input int a, input logic [63:0] d);
    hw_wr = 1; hw_add = a[4:0]; hw_wdat = d; tick(); idle();
  endtask
  task automatic hwr(input int a);
    hw_rd = 1; hw_add = a[4:0]; tick(); idle();
  endtask
  task automatic sww(input int a, input logic [63:0] d, input logic r);
    sw_cs = 1; sw_we = 1; sw_add = a[4:0]; sw_wdat = d; reset = r; tick(); idle();
  endtask
  task automatic swr(input int a);
    sw_cs = 1; sw_add = a[4:0]; tick(); idle();
  endtask
  task automatic cmp(input logic [63:0] key);
    sw_cs = 1; sw_ce = 1; sw_wdat = key; tick(); idle();
  endtask
  initial begin
    tick(); tick();
    chk("rst_sw_rdat", sw_rdat, 0);
    chk("rst_sw_match", {63'b0, sw_match}, 0);
    chk("rst_sw_aindex", {60'b0, sw_aindex}, 0);
    chk("rst_hw_rdat", hw_rdat, 0);
    chk("rst_hw_rvalid", {63'b0, hw_rvalid}, 0);
    chk("rst_grant", {63'b0, grant}, 0);
    chk("rst_hw_stall", {63'b0, hw_stall}, 0);
    rst_n = 1; tick();
    hww(3, 64'hA5);
    sw_cs = 1; sw_add = 5'd3; #1;
    chk("sw_grant_idle", {63'b0, grant}, 1);
    tick(); idle();
    chk("sw_rd_a5", sw_rdat, 64'hA5);
    sw_cs = 1; sw_add = 5'd0; hw_rd = 1; hw_add = 5'd3; #1;
    chk("hw_prio_grant", {63'b0, grant}, 0);
    chk("hw_prio_stall", {63'b0, hw_stall}, 0);
    tick(); idle();
    chk("hw_prio_rvalid", {63'b0, hw_rvalid}, 1);
    chk("hw_prio_rdat", hw_rdat, 64'hA5);
    chk("sw_rdat_held", sw_rdat, 64'hA5);
    sw_cs = 1; sw_add = 5'd0; hw_rd = 1; hw_add = 5'd3; yield = 1; #1;
    chk("yield_grant", {63'b0, grant}, 1);
    chk("yield_stall", {63'b0, hw_stall}, 1);
    tick(); idle();
    chk("yield_rvalid", {63'b0, hw_rvalid}, 0);
    chk("yield_sw_rdat", sw_rdat, 0);
    hww(2, 64'h1234);
    sww(7, 64'h1234, 0);
    cmp(64'h1234);
    chk("cmp_hit", {63'b0, sw_match}, 1);
    chk("cmp_hit_idx", {60'b0, sw_aindex}, 2);
    swr(7);
    chk("cmp_hold", {63'b0, sw_match}, 1);
    chk("sw_rd7", sw_rdat, 64'h1234);
    cmp(64'h9999);
    chk("cmp_miss", {63'b0, sw_match}, 0);
    chk("cmp_miss_idx", {60'b0, sw_aindex}, 0);
    cmp(64'hA5);
    chk("cmp_idx3", {60'b0, sw_aindex}, 3);
    hww(5, 64'hFF);
    swr(5);
    chk("rd5_ff", sw_rdat, 64'hFF);
    sww(5, 64'hDEAD, 1);
    swr(5);
    chk("clear5", sw_rdat, 0);
    sww(20, 64'h77, 0);
    hwr(20);
    chk("oor_rvalid", {63'b0, hw_rvalid}, 1);
    chk("oor_rdat", hw_rdat, 0);
    cmp(64'h77);
    chk("oor_no_write", {63'b0, sw_match}, 0);
    hw_rd = 1; hw_wr = 1; hw_add = 5'd6; hw_wdat = 64'h66; tick(); idle();
    chk("rdwr_no_rvalid", {63'b0, hw_rvalid}, 0);
    hwr(6);
    chk("rdwr_wrote", hw_rdat, 64'h66);
    for (int i = 0; i < 16; i++) hww(i, 64'(i + 1));
    cmp(64'd16);
    chk("full_match", {63'b0, sw_match}, 1);
    chk("full_idx", {60'b0, sw_aindex}, 15);
    hw_rd = 1; hw_add = 5'd4; tick();
    rst_n = 0; hw_rd = 0; hw_wr = 1; hw_add = 5'd0; hw_wdat = 64'hBEEF; tick(); idle();
    rst_n = 1;
    chk("rstmid_rvalid", {63'b0, hw_rvalid}, 0);
    chk("rstmid_match", {63'b0, sw_match}, 0);
    chk("rstmid_aindex", {60'b0, sw_aindex}, 0);
    for (int i = 0; i < 16; i++) begin
      hwr(i);
      chk($sformatf("rst_entry%0d", i), hw_rdat, 0);
    end
    cmp(64'd0);
    chk("rst_cmp_idx0", {63'b0, sw_match}, 1);
`ifdef NX_IA_RESP_PARITY_EN
    hww(1, 64'h3);
    dut.entries_q[1] = 64'h2;
    hwr(1);
    chk("perr_rvalid", {63'b0, hw_rvalid}, 1);
    chk("perr_flag", {63'b0, hw_perr}, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
